n2r_pingpong_buffer_i: RTL and testbench
========================================

// Module: n2r_pingpong_buffer_i
// PURPOSE
//  Normal-to-ready converter for the INPUT matrix, next generation. Accepts one full matrix row per
//  handshake, collects SLICE_ROWS rows into one of two ping-pong banks and emits, per output beat,
//  one BLOCK_SIZE x BLOCK_SIZE block per core for the multi-MAC array. Filling one bank overlaps
//  with draining the other. Valid/ready on both sides, so the array may stall the stream.
// PARAMETERS
//  WIDTH       16   element width, bits (fixed-point, passed through untouched)
//  FRAC_WIDTH  8    fraction bits; informational only, no arithmetic in this block
//  BLOCK_SIZE  2    block edge; CHUNK_SIZE = BLOCK_SIZE*BLOCK_SIZE
//  NUM_CORES   2    cores fed per beat; SLICE_ROWS = BLOCK_SIZE*NUM_CORES
//  ROW         8    matrix rows; must be a multiple of SLICE_ROWS (elaboration error otherwise)
//  COL         4    matrix columns; must be a multiple of BLOCK_SIZE (elaboration error otherwise)
// PORTS
//  clk           in   1                        rising-edge clock
//  rst_n         in   1                        async active-low reset
//  start         in   1                        pulse in IDLE: begin one matrix
//  in_valid      in   1                        in_data holds a valid row
//  in_ready      out  1                        row accepted when in_valid && in_ready
//  in_data       in   WIDTH*COL                row; column 0 in the MSBs
//  out_valid     out  1                        out_data holds a valid beat
//  out_ready     in   1                        beat consumed when out_valid && out_ready
//  out_data      out  WIDTH*CHUNK_SIZE*NUM_CORES  one block per core; core 0 in the MSBs
//  slice_done    out  1                        1-cycle pulse: last beat of a slice consumed
//  buffer_done   out  1                        1-cycle pulse: last beat of the matrix consumed
// BEHAVIOUR
//  Reset: all outputs 0 (in_ready, out_valid, out_data, slice_done, buffer_done). FSM to IDLE,
//   both banks EMPTY, all counters 0. Asynchronous; reset mid-matrix discards everything.
//  Top FSM:
//   IDLE -> RUN on start.
//   RUN -> DONE in the cycle the final beat is consumed; buffer_done pulses that cycle.
//   DONE -> IDLE on the next cycle. start outside IDLE is ignored.
//  Bank FSM, per bank: EMPTY -> FILL (first row written) -> FULL (row SLICE_ROWS-1 written)
//   -> DRAIN (selected by read side) -> EMPTY (last chunk consumed).
//   Write pointer and read pointer each toggle banks; bank 0 is used first.
//  in_ready = RUN && write bank not FULL/DRAIN && rows_accepted < ROW. Registered.
//   A bank freed in cycle t is writable from cycle t+1. Row r of the slice goes to bank line r.
//  Output: registered stage. It loads a new beat when (!out_valid || out_ready) and the read
//   bank is FULL or DRAIN. The first beat of a slice appears the cycle after its last row write.
//   Chunk index c runs 0..COL/BLOCK_SIZE-1 per slice; full throughput is 1 beat/cycle with no
//   bubbles across slices if the next bank is already FULL.
//  Beat mapping for core k, block element (r,j), r,j in 0..BLOCK_SIZE-1:
//   source = bank line k*BLOCK_SIZE+r, column c*BLOCK_SIZE+j
//   placed at out_data[OUT_W-1-(k*CHUNK_SIZE+r*BLOCK_SIZE+j)*WIDTH -: WIDTH]
//  out_data holds its value while out_valid && !out_ready; data never changes under a stall.
//  slice_done pulses on consumption of chunk COL/BLOCK_SIZE-1. On the matrix's final beat,
//   slice_done and buffer_done pulse in the same cycle.
//  Simultaneous write into bank A and drain of bank B is the normal case and is legal.
//   in_valid while in_ready=0 is held off with no loss.
// STRUCTURE
//  Package n2r_pkg: derived constants (CHUNK_SIZE, SLICE_ROWS, CHUNKS_PER_ROW,
//   SLICES = ROW/SLICE_ROWS, OUT_W), top and bank state encodings.
//  Sub-module n2r_slice_bank: SLICE_ROWS x (WIDTH*COL) register bank, one row write port,
//   combinational chunk-read port (chunk index -> NUM_CORES blocks). Instantiated twice.
//   Top holds the FSMs, pointers, counters and output register.
// TESTING (WIDTH=16, BLOCK_SIZE=2, NUM_CORES=2, ROW=8, COL=4; element(r,c) = r*16+c)
//  1 Reset values: hold rst_n=0 -> all outputs 0. Release with no start -> in_ready stays 0.
//  2 Full stream, out_ready=1, in_valid=1 from start:
//    - beat0 = {00,01,10,11, 20,21,30,31}; beat1 = {02,03,12,13, 22,23,32,33}
//    - slice_done after beat1; 4 beats total; buffer_done with beat3; then back to IDLE.
//  3 Overlap: rows 4..7 accepted while beats 0..1 drain. Beat2 = {40,41,50,51,60,61,70,71}
//    follows beat1 with no bubble.
//  4 Back-pressure: out_ready=0 for 5 cycles at beat1 -> out_data stable. Both banks FULL ->
//    in_ready=0, no rows lost; stream resumes correctly.
//  5 Reset mid-matrix: rst_n low after 3 rows -> outputs 0 immediately. A new start then
//    yields beat0 from fresh data.
//  6 Random in_valid/out_ready (30% idle) over 200 matrices -> scoreboard exact match;
//    one buffer_done per matrix.

Source files
------------

// File: rtl/n2r_pkg.sv
// n2r_pkg: shared configuration for the input-matrix normal-to-ready converter.
// Holds the base geometry, every derived constant, and the top-level and
// per-bank state encodings used by n2r_pingpong_buffer_i and n2r_slice_bank.
package n2r_pkg;

    // Smallest counter width able to index n items; never narrower than 1 bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Base geometry. FRAC_WIDTH only documents the fixed-point format;
    // elements pass through this block untouched.
    localparam int WIDTH      = 16;
    localparam int FRAC_WIDTH = 8;
    localparam int BLOCK_SIZE = 2;
    localparam int NUM_CORES  = 2;
    localparam int ROW        = 8;
    localparam int COL        = 4;

    // Derived geometry.
    localparam int CHUNK_SIZE     = BLOCK_SIZE * BLOCK_SIZE;
    localparam int SLICE_ROWS     = BLOCK_SIZE * NUM_CORES;
    localparam int CHUNKS_PER_ROW = COL / BLOCK_SIZE;
    localparam int SLICES         = ROW / SLICE_ROWS;
    localparam int ROW_W          = WIDTH * COL;
    localparam int OUT_W          = WIDTH * CHUNK_SIZE * NUM_CORES;

    // Counter widths.
    localparam int LINE_W = clog2_min1(SLICE_ROWS);
    localparam int CIDX_W = clog2_min1(CHUNKS_PER_ROW);
    localparam int SIDX_W = clog2_min1(SLICES);
    localparam int ROWS_W = $clog2(ROW + 1);

    // Top-level sequencing states.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Per-bank occupancy states.
    localparam logic [1:0] B_EMPTY = 2'd0;
    localparam logic [1:0] B_FILL  = 2'd1;
    localparam logic [1:0] B_FULL  = 2'd2;
    localparam logic [1:0] B_DRAIN = 2'd3;

endpackage

// File: rtl/n2r_slice_bank.sv
// n2r_slice_bank: one ping-pong bank holding SLICE_ROWS matrix rows.
// Ports:
//   clk       rising-edge clock
//   wr_en     write wr_data into line wr_line this cycle
//   wr_line   destination line (row index within the slice)
//   wr_data   one full matrix row, column 0 in the MSBs
//   rd_chunk  chunk index c selecting columns c*BLOCK_SIZE .. c*BLOCK_SIZE+BLOCK_SIZE-1
//   rd_data   NUM_CORES blocks of BLOCK_SIZE x BLOCK_SIZE, core 0 in the MSBs (combinational)
module n2r_slice_bank
    import n2r_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [LINE_W-1:0] wr_line,
    input  logic [ROW_W-1:0]  wr_data,
    input  logic [CIDX_W-1:0] rd_chunk,
    output logic [OUT_W-1:0]  rd_data
);

    logic [ROW_W-1:0] mem [SLICE_ROWS];

    // NOTE: the storage array has no reset; the bank state machine in the top
    // decides when lines hold valid data, so clearing them would only add logic.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_line] <= wr_data;
        end
    end

    // Core k, block element (r,j) comes from line k*BLOCK_SIZE+r, column
    // rd_chunk*BLOCK_SIZE+j, and lands at flat position k*CHUNK_SIZE+r*BLOCK_SIZE+j
    // counted from the MSB end.
    // NOTE: rd_data is assigned a default before the loops so no latch is inferred.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            for (int r = 0; r < BLOCK_SIZE; r++) begin
                for (int j = 0; j < BLOCK_SIZE; j++) begin
                    rd_data[OUT_W-1-(k*CHUNK_SIZE+r*BLOCK_SIZE+j)*WIDTH -: WIDTH] =
                        mem[k*BLOCK_SIZE+r][ROW_W-1-(int'(rd_chunk)*BLOCK_SIZE+j)*WIDTH -: WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/n2r_pingpong_buffer_i.sv
// n2r_pingpong_buffer_i: converts a row-major input matrix into per-core
// BLOCK_SIZE x BLOCK_SIZE blocks. Rows fill one bank while the other bank drains.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begin one matrix (honoured only when idle)
//   in_valid     in_data holds a row;  in_ready: row accepted on in_valid && in_ready
//   in_data      one row, column 0 in the MSBs
//   out_valid    out_data holds a beat; out_ready: beat consumed on out_valid && out_ready
//   out_data     one block per core, core 0 in the MSBs
//   slice_done   pulses while the last beat of a slice is consumed
//   buffer_done  pulses while the last beat of the matrix is consumed
module n2r_pingpong_buffer_i
    import n2r_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ROW_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             slice_done,
    output logic             buffer_done
);

    if (ROW % SLICE_ROWS != 0) begin : g_bad_row
        $error("ROW must be a multiple of BLOCK_SIZE*NUM_CORES");
    end
    if (COL % BLOCK_SIZE != 0) begin : g_bad_col
        $error("COL must be a multiple of BLOCK_SIZE");
    end

    logic [1:0]        state, state_nx;
    logic [1:0][1:0]   bank_st, bank_nx;
    logic              wr_bank, wr_bank_nx;
    logic              rd_bank;
    logic [LINE_W-1:0] wr_line, wr_line_nx;
    logic [ROWS_W-1:0] rows_acc, rows_nx;
    logic [CIDX_W-1:0] rd_chunk;
    logic [SIDX_W-1:0] rd_slice;
    logic              out_bank, out_last_chunk, out_last_matrix;
    logic              in_ready_nx;
    logic [OUT_W-1:0]  bank_rd [2];

    logic start_fire, wr_fire, out_fire, last_row, rd_last, rd_avail, load;

    assign start_fire = (state == S_IDLE) && start;
    assign wr_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign last_row   = (wr_line == LINE_W'(SLICE_ROWS - 1));
    assign rd_last    = (rd_chunk == CIDX_W'(CHUNKS_PER_ROW - 1));
    assign rd_avail   = (bank_st[rd_bank] == B_FULL) || (bank_st[rd_bank] == B_DRAIN);
    // The read pointer leaves a bank as soon as its last chunk is loaded, so a
    // DRAIN bank under the read pointer always still has chunks to send.
    assign load       = (state == S_RUN) && (!out_valid || out_ready) && rd_avail;

    assign slice_done  = out_fire && out_last_chunk;
    assign buffer_done = out_fire && out_last_matrix;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        n2r_slice_bank u_bank (
            .clk      (clk),
            .wr_en    (wr_fire && (wr_bank == 1'(g))),
            .wr_line  (wr_line),
            .wr_data  (in_data),
            .rd_chunk (rd_chunk),
            .rd_data  (bank_rd[g])
        );
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (out_fire && out_last_matrix) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Write and read sides never touch the same bank in one cycle, and a bank
    // is only released once the beat carrying its last chunk has left.
    always_comb begin
        bank_nx = bank_st;
        for (int b = 0; b < 2; b++) begin
            if (wr_fire && wr_bank == 1'(b)) bank_nx[b] = last_row ? B_FULL : B_FILL;
            if (load && rd_bank == 1'(b)) bank_nx[b] = B_DRAIN;
            if (out_fire && out_last_chunk && out_bank == 1'(b)) bank_nx[b] = B_EMPTY;
        end
    end

    always_comb begin
        wr_bank_nx = wr_bank;
        wr_line_nx = wr_line;
        rows_nx    = rows_acc;
        if (start_fire) begin
            wr_bank_nx = 1'b0;
            wr_line_nx = '0;
            rows_nx    = '0;
        end else if (wr_fire) begin
            wr_bank_nx = wr_bank ^ last_row;
            wr_line_nx = last_row ? '0 : wr_line + 1'b1;
            rows_nx    = rows_acc + 1'b1;
        end
    end

    // Registered ready, computed from next-cycle state so a bank freed in
    // this cycle is writable in the next one.
    assign in_ready_nx = (state_nx == S_RUN) &&
                         (bank_nx[wr_bank_nx] != B_FULL) &&
                         (bank_nx[wr_bank_nx] != B_DRAIN) &&
                         (rows_nx < ROWS_W'(ROW));

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            bank_st         <= {B_EMPTY, B_EMPTY};
            wr_bank         <= 1'b0;
            wr_line         <= '0;
            rows_acc        <= '0;
            in_ready        <= 1'b0;
            rd_bank         <= 1'b0;
            rd_chunk        <= '0;
            rd_slice        <= '0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_bank        <= 1'b0;
            out_last_chunk  <= 1'b0;
            out_last_matrix <= 1'b0;
        end else begin
            state    <= state_nx;
            bank_st  <= bank_nx;
            wr_bank  <= wr_bank_nx;
            wr_line  <= wr_line_nx;
            rows_acc <= rows_nx;
            in_ready <= in_ready_nx;

            if (start_fire) begin
                rd_bank  <= 1'b0;
                rd_chunk <= '0;
                rd_slice <= '0;
            end else if (load) begin
                rd_chunk <= rd_last ? '0 : rd_chunk + 1'b1;
                if (rd_last) begin
                    rd_bank  <= ~rd_bank;
                    rd_slice <= rd_slice + 1'b1;
                end
            end

            if (load) begin
                out_valid       <= 1'b1;
                out_data        <= rd_bank ? bank_rd[1] : bank_rd[0];
                out_bank        <= rd_bank;
                out_last_chunk  <= rd_last;
                out_last_matrix <= rd_last && (rd_slice == SIDX_W'(SLICES - 1));
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_n2r_pingpong_buffer_i.sv
// Testbench for n2r_pingpong_buffer_i: directed stream, overlap, back-pressure
// and mid-matrix reset scenarios, then 200 random matrices. Expected beats are
// derived from the whole matrix and queued; a monitor pops them on consumption.
module tb_n2r_pingpong_buffer_i;
    import n2r_pkg::*;

    localparam int BEATS = SLICES * CHUNKS_PER_ROW;

    typedef struct {
        logic [OUT_W-1:0] data;
        bit               sd;
        bit               bd;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [ROW_W-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic             slice_done;
    logic             buffer_done;

    int total = 0;
    int bad = 0;
    int bd_count = 0;
    int rows_in = 0;
    int cyc = 0;
    int cur_beat = 0;
    int fire_cyc [BEATS];
    int rows_at_fire [BEATS];
    bit rand_ready = 1'b0;
    int in_idle_pct = 0;
    exp_t exp_q [$];
    logic [WIDTH-1:0] mat [ROW][COL];
    logic [OUT_W-1:0] held_data = '0;
    bit held_valid = 1'b0;

    n2r_pingpong_buffer_i dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .slice_done  (slice_done),
        .buffer_done (buffer_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every consumed beat with the head of the queue and
    // verifies that a stalled beat stays put.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_valid = 1'b0;
            cur_beat   = 0;
        end else begin
            if (held_valid) begin
                check("stall_valid", OUT_W'(out_valid), OUT_W'(1));
                check("stall_data", out_data, held_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", out_data, '0);
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got a beat, expected none queued");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("beat_data", out_data, e.data);
                    check("slice_done", OUT_W'(slice_done), OUT_W'(e.sd));
                    check("buffer_done", OUT_W'(buffer_done), OUT_W'(e.bd));
                end
                if (cur_beat < BEATS) begin
                    fire_cyc[cur_beat]     = cyc;
                    rows_at_fire[cur_beat] = rows_in;
                end
                cur_beat++;
                if (buffer_done) begin
                    bd_count++;
                    cur_beat = 0;
                end
            end else begin
                check("idle_pulses", OUT_W'({slice_done, buffer_done}), '0);
            end
            held_valid = out_valid && !out_ready;
            held_data  = out_data;
        end
    end

    // Random consumer, active only when the test hands out_ready over.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 99) >= 30);
        end
    end

    function automatic logic [ROW_W-1:0] pack_row(input int r);
        logic [ROW_W-1:0] v = '0;
        for (int c = 0; c < COL; c++) v = (v << WIDTH) | ROW_W'(mat[r][c]);
        return v;
    endfunction

    // Fills the matrix, queues its expected beats in consumption order and
    // pulses start. Runs from and returns to posedge+1.
    task automatic begin_matrix(input bit random_data);
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++)
                mat[r][c] = random_data ? WIDTH'($urandom) : WIDTH'(r * 16 + c);
        for (int s = 0; s < SLICES; s++) begin
            for (int c = 0; c < CHUNKS_PER_ROW; c++) begin
                exp_t e;
                e.data = '0;
                for (int k = 0; k < NUM_CORES; k++)
                    for (int r = 0; r < BLOCK_SIZE; r++)
                        for (int j = 0; j < BLOCK_SIZE; j++)
                            e.data = (e.data << WIDTH) |
                                     OUT_W'(mat[s*SLICE_ROWS + k*BLOCK_SIZE + r][c*BLOCK_SIZE + j]);
                e.sd = (c == CHUNKS_PER_ROW - 1);
                e.bd = e.sd && (s == SLICES - 1);
                exp_q.push_back(e);
            end
        end
        rows_in  = 0;
        cur_beat = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_row(input int r);
        bit done = 1'b0;
        int budget = 0;
        while (!done) begin
            in_data  = pack_row(r);
            in_valid = !(in_idle_pct > 0 && $urandom_range(0, 99) < in_idle_pct);
            @(negedge clk);
            if (in_valid && in_ready) begin
                done = 1'b1;
                rows_in++;
            end
            @(posedge clk);
            #1;
            budget++;
            if (!done && budget > 1000) begin
                check("row_accept_timeout", OUT_W'(rows_in), OUT_W'(r + 1));
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 3000 && bd_count < target; i++) @(posedge clk);
        #1;
        check("matrix_done", OUT_W'(bd_count), OUT_W'(target));
        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", OUT_W'(exp_q.size()), '0);
        check("idle_in_ready", OUT_W'(in_ready), '0);
    endtask

    task automatic run_matrix(input bit random_data);
        int target = bd_count + 1;
        begin_matrix(random_data);
        for (int r = 0; r < ROW; r++) send_row(r);
        wait_done(target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int target;

        // 1: reset values, then no start keeps in_ready low.
        repeat (3) @(negedge clk);
        check("rst_in_ready", OUT_W'(in_ready), '0);
        check("rst_out_valid", OUT_W'(out_valid), '0);
        check("rst_out_data", out_data, '0);
        check("rst_slice_done", OUT_W'(slice_done), '0);
        check("rst_buffer_done", OUT_W'(buffer_done), '0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("nostart_in_ready", OUT_W'(in_ready), '0);
        end
        @(posedge clk);
        #1;

        // 2 and 3: full-rate stream with known data; rows of the second
        // slice must already be arriving while the first slice drains.
        out_ready = 1'b1;
        run_matrix(1'b0);
        check("overlap_rows", OUT_W'(rows_at_fire[1] >= SLICE_ROWS + 1), OUT_W'(1));

        // 4: back-pressure with both banks loaded, stall on beat 1.
        target = bd_count + 1;
        out_ready = 1'b0;
        begin_matrix(1'b1);
        for (int r = 0; r < ROW; r++) send_row(r);
        repeat (3) @(posedge clk);
        #1;
        check("bp_in_ready", OUT_W'(in_ready), '0);
        check("bp_out_valid", OUT_W'(out_valid), OUT_W'(1));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(target);
        check("bp_no_bubble_12", OUT_W'(fire_cyc[2] - fire_cyc[1]), OUT_W'(1));
        check("bp_no_bubble_23", OUT_W'(fire_cyc[3] - fire_cyc[2]), OUT_W'(1));

        // 5: reset after three rows, then a fresh matrix.
        begin_matrix(1'b1);
        for (int r = 0; r < 3; r++) send_row(r);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", OUT_W'(in_ready), '0);
        check("midrst_out_valid", OUT_W'(out_valid), '0);
        check("midrst_out_data", out_data, '0);
        check("midrst_pulses", OUT_W'({slice_done, buffer_done}), '0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_matrix(1'b1);

        // 6: random traffic on both sides.
        target = bd_count + 200;
        rand_ready  = 1'b1;
        in_idle_pct = 30;
        for (int m = 0; m < 200; m++) run_matrix(1'b1);
        check("random_done_count", OUT_W'(bd_count), OUT_W'(target));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
